// File: rtl/ppu_pkg.sv
// ppu_pkg: shared definitions for the sprite line evaluation stage.
//   - OAM entry field bit positions (32-bit entry)
//   - Slot field layout (SLOT_W = 24) and a packing helper
//   - Default slot count and evaluation FSM state encoding
package ppu_pkg;

  // OAM entry fields
  localparam int OAM_Y_LSB     = 0;
  localparam int OAM_Y_MSB     = 8;
  localparam int OAM_X_LSB     = 9;
  localparam int OAM_X_MSB     = 17;
  localparam int OAM_TILE_LSB  = 18;
  localparam int OAM_TILE_MSB  = 25;
  localparam int OAM_HFLIP_BIT = 26;
  localparam int OAM_VFLIP_BIT = 27;
  localparam int OAM_PRIO_BIT  = 28;
  localparam int OAM_TALL_BIT  = 29;

  // Slot layout: {prio, hflip, row[3:0], tile[7:0], x[8:0], pad}
  localparam int SLOT_W         = 24;
  localparam int SLOT_PRIO_BIT  = 23;
  localparam int SLOT_HFLIP_BIT = 22;
  localparam int SLOT_ROW_MSB   = 21;
  localparam int SLOT_ROW_LSB   = 18;
  localparam int SLOT_TILE_MSB  = 17;
  localparam int SLOT_TILE_LSB  = 10;
  localparam int SLOT_X_MSB     = 9;
  localparam int SLOT_X_LSB     = 1;
  localparam int SLOT_PAD_BIT   = 0;

  localparam int MAX_SLOTS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FIN   = 2'd3
  } eval_state_e;

  // Assemble one slot word from its fields.
  function automatic logic [SLOT_W-1:0] slot_pack(
    input logic       prio,
    input logic       hflip,
    input logic [3:0] row,
    input logic [7:0] tile,
    input logic [8:0] x
  );
    logic [SLOT_W-1:0] s;
    s = '0;
    s[SLOT_PRIO_BIT]                = prio;
    s[SLOT_HFLIP_BIT]               = hflip;
    s[SLOT_ROW_MSB:SLOT_ROW_LSB]    = row;
    s[SLOT_TILE_MSB:SLOT_TILE_LSB]  = tile;
    s[SLOT_X_MSB:SLOT_X_LSB]        = x;
    s[SLOT_PAD_BIT]                 = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/sprite_line_eval_if.sv
// sprite_line_eval_if: OAM read bus between the evaluator and OAM.
//   oam_rd_en  - read strobe (master -> slave)
//   oam_addr   - entry address (master -> slave)
//   oam_rdata  - entry data, valid one cycle after oam_rd_en (slave -> master)
interface sprite_line_eval_if #(
  parameter int AW = 6
);
  logic          oam_rd_en;
  logic [AW-1:0] oam_addr;
  logic [31:0]   oam_rdata;

  modport master (output oam_rd_en, output oam_addr, input oam_rdata);
  modport slave  (input oam_rd_en, input oam_addr, output oam_rdata);
endinterface

// File: rtl/sprite_slot_buf.sv
// sprite_slot_buf: DEPTH x SLOT_W register file holding the sprites
// selected for one line.
//   clk, rst  - clock, synchronous active-high reset (clears all slots)
//   clr       - clear all slots
//   we        - write enable, wr_idx / wr_data select slot and contents
//   rd_idx    - combinational read index, rd_data its contents
module sprite_slot_buf
  import ppu_pkg::*;
#(
  parameter int DEPTH = MAX_SLOTS_DEF,
  parameter int IW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [IW-1:0]     wr_idx,
  input  logic [SLOT_W-1:0] wr_data,
  input  logic [IW-1:0]     rd_idx,
  output logic [SLOT_W-1:0] rd_data
);

  logic [SLOT_W-1:0] mem_r [DEPTH];

  // Slot storage: clear-all has priority over a write.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/sprite_line_eval.sv
// sprite_line_eval: per-scanline sprite evaluation.
// On a start pulse, scans all OAM entries for sprites covering line_y and
// latches up to MAX_SLOTS hits (in OAM order) into the slot buffer.
// Optional feature macro: SPRITE_TALL_EN (per-entry double-height sprites).
//   clk, rst    - clock, synchronous active-high reset
//   start       - begin evaluation of line_y (restarts an active scan)
//   line_y      - target line, sampled on start
//   oam         - OAM read bus (master side)
//   busy        - scan in progress
//   done        - one-cycle pulse when slot buffer is final
//   slot_count  - number of valid slots
//   overflow    - more than MAX_SLOTS hits on the line
//   slot_idx    - slot read index, slot_data its contents (0 if unused)
module sprite_line_eval
  import ppu_pkg::*;
#(
  parameter int OAM_ENTRIES = 64,
  parameter int OAM_AW      = 6,
  parameter int MAX_SLOTS   = MAX_SLOTS_DEF,
  parameter int SPR_H       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8:0]         line_y,
  sprite_line_eval_if.master oam,
  output logic               busy,
  output logic               done,
  output logic [3:0]         slot_count,
  output logic               overflow,
  input  logic [2:0]         slot_idx,
  output logic [SLOT_W-1:0]  slot_data
);

  localparam logic [OAM_AW-1:0] LAST_ADDR  = OAM_AW'(OAM_ENTRIES - 1);
  localparam logic [3:0]        SLOTS_FULL = 4'(MAX_SLOTS);
  localparam logic [8:0]        H_NORM     = 9'(SPR_H);
`ifdef SPRITE_TALL_EN
  localparam logic [8:0]        H_TALL     = 9'(2 * SPR_H);
`endif

  eval_state_e       state_r, state_s;
  logic [8:0]        line_r;
  logic [OAM_AW-1:0] addr_r;
  logic              rd_en_r;
  logic              rd_vld_r;   // oam_rdata holds an entry to evaluate
  logic [3:0]        count_r;
  logic              ovf_r;
  logic              busy_r;
  logic              done_r;

  logic [8:0]        ent_y_s;
  logic [8:0]        diff_s;
  logic [8:0]        height_s;
  logic [8:0]        row_full_s;
  logic [3:0]        row_s;
  logic              eval_s;
  logic              hit_s;
  logic              wr_s;
  logic              full_hit_s;
  logic [SLOT_W-1:0] wr_data_s;
  logic [SLOT_W-1:0] rd_data_s;
  logic              unused_s;

  // Compare stage: decide whether the returned entry covers the line.
  always_comb begin
    ent_y_s = oam.oam_rdata[OAM_Y_MSB:OAM_Y_LSB];
    // 9-bit wrap-around: sprites near y=511 reach into lines 0..height-2
    diff_s  = line_r - ent_y_s;
`ifdef SPRITE_TALL_EN
    if (oam.oam_rdata[OAM_TALL_BIT]) begin
      height_s = H_TALL;
    end else begin
      height_s = H_NORM;
    end
`else
    height_s = H_NORM;
`endif
    if (oam.oam_rdata[OAM_VFLIP_BIT]) begin
      row_full_s = height_s - 9'd1 - diff_s;
    end else begin
      row_full_s = diff_s;
    end
`ifdef SPRITE_TALL_EN
    row_s = row_full_s[3:0];
`else
    row_s = {1'b0, row_full_s[2:0]};
`endif
    // A start pulse discards whatever read is in flight.
    eval_s     = rd_vld_r && !start && ((state_r == ST_SCAN) || (state_r == ST_FLUSH));
    hit_s      = eval_s && (diff_s < height_s);
    wr_s       = hit_s && (count_r < SLOTS_FULL);
    full_hit_s = hit_s && !(count_r < SLOTS_FULL);
    wr_data_s  = slot_pack(oam.oam_rdata[OAM_PRIO_BIT], oam.oam_rdata[OAM_HFLIP_BIT], row_s,
                           oam.oam_rdata[OAM_TILE_MSB:OAM_TILE_LSB],
                           oam.oam_rdata[OAM_X_MSB:OAM_X_LSB]);
  end

  assign unused_s = ^{oam.oam_rdata[31:29], row_full_s[8:3]};

  // Next-state logic: start always (re)enters SCAN.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SCAN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (start) begin
          state_s = ST_SCAN;
        end else if (full_hit_s) begin
          state_s = ST_FIN;
        end else if (addr_r == LAST_ADDR) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_SCAN;
        end
      end
      ST_FLUSH: begin
        if (start) begin
          state_s = ST_SCAN;
        end else begin
          state_s = ST_FIN;
        end
      end
      ST_FIN: begin
        if (start) begin
          state_s = ST_SCAN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, address generator, slot counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      line_r   <= 9'd0;
      addr_r   <= '0;
      rd_en_r  <= 1'b0;
      rd_vld_r <= 1'b0;
      count_r  <= 4'd0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= (state_r == ST_FIN);
      busy_r  <= (state_s != ST_IDLE);
      rd_en_r <= (state_s == ST_SCAN);
      if (start) begin
        line_r   <= line_y;
        addr_r   <= '0;
        rd_vld_r <= 1'b0;
        count_r  <= 4'd0;
        ovf_r    <= 1'b0;
      end else begin
        // the read issued now is evaluated only if the scan continues
        rd_vld_r <= rd_en_r && ((state_s == ST_SCAN) || (state_s == ST_FLUSH));
        if ((state_r == ST_SCAN) && (state_s == ST_SCAN)) begin
          addr_r <= addr_r + 1'b1;
        end else begin
          addr_r <= '0;
        end
        if (wr_s) begin
          count_r <= count_r + 4'd1;
        end
        if (full_hit_s) begin
          ovf_r <= 1'b1;
        end
      end
    end
  end

  sprite_slot_buf #(
    .DEPTH (MAX_SLOTS),
    .IW    (3)
  ) u_slot_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .we      (wr_s),
    .wr_idx  (count_r[2:0]),
    .wr_data (wr_data_s),
    .rd_idx  (slot_idx),
    .rd_data (rd_data_s)
  );

  assign oam.oam_rd_en = rd_en_r;
  assign oam.oam_addr  = addr_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign slot_count    = count_r;
  assign overflow      = ovf_r;
  assign slot_data     = ({1'b0, slot_idx} < count_r) ? rd_data_s : '0;

endmodule

// File: tb/tb_sprite_line_eval.sv
module tb_sprite_line_eval;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  line_y;
  logic        busy;
  logic        done;
  logic [3:0]  slot_count;
  logic        overflow;
  logic [2:0]  slot_idx;
  logic [23:0] slot_data;

  sprite_line_eval_if #(.AW(6)) oam_bus ();

  sprite_line_eval dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .line_y     (line_y),
    .oam        (oam_bus),
    .busy       (busy),
    .done       (done),
    .slot_count (slot_count),
    .overflow   (overflow),
    .slot_idx   (slot_idx),
    .slot_data  (slot_data)
  );

  always #5 clk = ~clk;

  // OAM memory: one-cycle read latency
  logic [31:0] oam_mem [64];
  always @(posedge clk) begin
    if (oam_bus.oam_rd_en) oam_bus.oam_rdata <= oam_mem[oam_bus.oam_addr];
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mk_ent(input int y, input int x, input int tile,
                                         input bit hflip, input bit vflip, input bit prio, input bit tall);
    logic [8:0] yy; logic [8:0] xx; logic [7:0] tt;
    yy = 9'(y); xx = 9'(x); tt = 8'(tile);
    return {2'b00, tall, prio, vflip, hflip, tt, xx, yy};
  endfunction

  task automatic fill_default();
    for (int i = 0; i < 64; i++) oam_mem[i] = mk_ent(300, i, i, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reference model: walk OAM in order, collect up to 8 hits.
  logic [23:0] exp_q[$];
  bit          exp_ovf;
  int          exp_lat;

  task automatic model_line(input logic [8:0] ly);
    int y; int h; int d; int r; logic [31:0] e; logic [3:0] r4;
    exp_q.delete();
    exp_ovf = 0;
    exp_lat = 64 + 3;
    for (int i = 0; i < 64; i++) begin
      e = oam_mem[i];
      y = int'(e[8:0]);
      h = 8;
`ifdef SPRITE_TALL_EN
      if (e[29]) h = 16;
`endif
      d = (int'(ly) - y + 512) % 512;
      if (d < h) begin
        if (exp_q.size() == 8) begin
          exp_ovf = 1;
          exp_lat = i + 4;  // read at cycle i+1, compared at i+2, FIN at i+3, done at i+4
          break;
        end
        r = (e[27] != 1'b0) ? (h - 1 - d) : d;
        r4 = 4'(r);
        exp_q.push_back({e[28], e[26], r4, e[25:18], e[17:9], 1'b0});
      end
    end
  endtask

  int          act_cnt;
  int          act_ovf;
  int          act_lat;
  logic [23:0] act_slot [8];

  task automatic pulse_start(input logic [8:0] ly);
    @(negedge clk);
    line_y = ly;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Wait for done (bounded) and compare everything against the model.
  task automatic finish_check(input string tag, input int first_cyc);
    int cyc; bit seen; logic [23:0] ev;
    cyc = first_cyc;
    seen = 0;
    while (!seen && cyc < 200) begin
      if (done === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    act_lat = cyc;
    check({tag, "_latency"}, act_lat, exp_lat);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    act_cnt = int'(slot_count);
    act_ovf = int'(overflow);
    check({tag, "_count"}, act_cnt, exp_q.size());
    check({tag, "_overflow"}, act_ovf, 32'(exp_ovf));
    for (int i = 0; i < 8; i++) begin
      slot_idx = 3'(i);
      #1;
      ev = (i < exp_q.size()) ? exp_q[i] : 24'd0;
      act_slot[i] = slot_data;
      check($sformatf("%s_slot%0d", tag, i), 32'(slot_data), 32'(ev));
    end
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic run_line(input logic [8:0] ly, input string tag);
    model_line(ly);
    pulse_start(ly);
    finish_check(tag, 1);
  endtask

  typedef struct packed {
    logic [8:0]       ly;
    logic [1:0]       n;
    logic [1:0][5:0]  idx;
    logic [1:0][31:0] ent;
    logic [3:0]       cnt;
    logic             ovf;
    logic [7:0]       lat;
    logic [3:0]       row0;
    logic [3:0]       row1;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int ly, input int n, input int i0, input logic [31:0] e0,
                         input int i1, input logic [31:0] e1, input int cnt, input int lat,
                         input int r0, input int r1);
    vec_t v;
    v.ly = 9'(ly); v.n = 2'(n);
    v.idx[0] = 6'(i0); v.ent[0] = e0;
    v.idx[1] = 6'(i1); v.ent[1] = e1;
    v.cnt = 4'(cnt); v.ovf = 1'b0; v.lat = 8'(lat);
    v.row0 = 4'(r0); v.row1 = 4'(r1);
    vecs.push_back(v);
  endtask

  int done_cnt;

  initial begin
    rst = 1'b1; start = 1'b0; line_y = 9'd0; slot_idx = 3'd0;
    fill_default();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_slot_count", 32'(slot_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rd_en", 32'(oam_bus.oam_rd_en), 32'd0);
    check("rst_addr", 32'(oam_bus.oam_addr), 32'd0);
    check("rst_slot_data", 32'(slot_data), 32'd0);
    rst = 1'b0;

    // ---- table-driven vectors ----
    add_vec(20, 2, 3, mk_ent(15, 40, 8'h11, 0, 0, 0, 0),
                   10, mk_ent(20, 100, 8'h22, 1, 0, 1, 0), 2, 67, 5, 0);
    add_vec(2, 1, 0, mk_ent(510, 7, 3, 0, 1, 0, 0), 0, 32'd0, 1, 67, 3, 0);
`ifdef SPRITE_TALL_EN
    add_vec(112, 1, 5, mk_ent(100, 60, 9, 0, 0, 0, 1), 0, 32'd0, 1, 67, 12, 0);
`else
    add_vec(112, 1, 5, mk_ent(100, 60, 9, 0, 0, 0, 1), 0, 32'd0, 0, 67, 0, 0);
`endif
    add_vec(20, 2, 0, mk_ent(13, 1, 1, 0, 0, 0, 0), 1, mk_ent(12, 2, 2, 0, 0, 0, 0), 1, 67, 7, 0);
    add_vec(0, 2, 7, mk_ent(504, 3, 4, 0, 0, 0, 0), 8, mk_ent(505, 5, 6, 0, 0, 0, 0), 1, 67, 7, 0);

    for (int v = 0; v < vecs.size(); v++) begin
      fill_default();
      for (int k = 0; k < int'(vecs[v].n); k++) oam_mem[vecs[v].idx[k]] = vecs[v].ent[k];
      run_line(vecs[v].ly, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_tbl_count", v), act_cnt, 32'(vecs[v].cnt));
      check($sformatf("vec%0d_tbl_ovf", v), act_ovf, 32'(vecs[v].ovf));
      check($sformatf("vec%0d_tbl_lat", v), act_lat, 32'(vecs[v].lat));
      check($sformatf("vec%0d_tbl_row0", v), 32'(act_slot[0][21:18]), 32'(vecs[v].row0));
      check($sformatf("vec%0d_tbl_row1", v), 32'(act_slot[1][21:18]), 32'(vecs[v].row1));
    end

    // ---- overflow: ten hits, scan aborts early ----
    fill_default();
    for (int i = 0; i < 10; i++) oam_mem[i] = mk_ent(50, i, 8'h40 + i, 0, 0, 0, 0);
    run_line(9'd52, "ovf");
    check("ovf_count8", act_cnt, 32'd8);
    check("ovf_flag", act_ovf, 32'd1);
    check("ovf_within12", 32'(act_lat <= 12), 32'd1);
    for (int i = 0; i < 8; i++) check($sformatf("ovf_order%0d", i), 32'(act_slot[i][9:1]), 32'(i));

    // ---- restart 30 cycles into a scan ----
    fill_default();
    for (int i = 0; i < 3; i++) oam_mem[i] = mk_ent(40, i, i, 0, 0, 0, 0);
    oam_mem[20] = mk_ent(100, 77, 8'h55, 0, 0, 1, 0);
    oam_mem[21] = mk_ent(95, 78, 8'h56, 1, 1, 0, 0);
    pulse_start(9'd40);
    done_cnt = 0;
    repeat (28) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("restart_no_early_done", done_cnt, 32'd0);
    run_line(9'd100, "restart");

    // ---- start in the FIN cycle ----
    fill_default();
    oam_mem[1] = mk_ent(60, 11, 1, 0, 0, 0, 0);
    oam_mem[2] = mk_ent(198, 12, 2, 0, 0, 0, 0);
    pulse_start(9'd60);
    repeat (65) @(negedge clk);
    check("fin_pre_done", 32'(done), 32'd0);
    check("fin_pre_busy", 32'(busy), 32'd1);
    line_y = 9'd200;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    check("fin_done_pulses", 32'(done), 32'd1);
    check("fin_busy_again", 32'(busy), 32'd1);
    model_line(9'd200);
    @(negedge clk);
    finish_check("fin_rescan", 2);

    // ---- reset mid-scan ----
    fill_default();
    for (int i = 0; i < 4; i++) oam_mem[i] = mk_ent(150, i, i, 0, 0, 0, 0);
    pulse_start(9'd150);
    repeat (20) @(negedge clk);
    check("midrst_pre_count", 32'(slot_count), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(slot_count), 32'd0);
    check("midrst_rd_en", 32'(oam_bus.oam_rd_en), 32'd0);
    check("midrst_addr", 32'(oam_bus.oam_addr), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    slot_idx = 3'd0;
    #1;
    check("midrst_slot0", 32'(slot_data), 32'd0);
    rst = 1'b0;
    run_line(9'd150, "post_rst");

    // ---- randomized lines against the model ----
    for (int t = 0; t < 25; t++) begin
      logic [8:0] ly; int p;
      ly = 9'($urandom_range(0, 511));
      p = int'($urandom_range(2, 8));
      for (int i = 0; i < 64; i++) begin
        logic [31:0] e;
        e = $urandom;
        if ($urandom_range(0, p) == 0) e[8:0] = ly - 9'($urandom_range(0, 17));
        oam_mem[i] = e;
      end
      run_line(ly, $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
